// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_pkg
//  Description : Shared definitions for the 8-slot TDM mux/demux pair:
//                slot count, slot index width, receiver state encoding and
//                channel-to-slot index constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    // Frame geometry is fixed; the mux side scans exactly eight selects.
    localparam int SLOTS  = 8;
    localparam int SLOT_W = 3;

    // Receiver alignment state.
    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Channel index constants, identical to the mux select values.
    localparam logic [SLOT_W-1:0] CH_A = 3'd0;
    localparam logic [SLOT_W-1:0] CH_B = 3'd1;
    localparam logic [SLOT_W-1:0] CH_C = 3'd2;
    localparam logic [SLOT_W-1:0] CH_D = 3'd3;
    localparam logic [SLOT_W-1:0] CH_E = 3'd4;
    localparam logic [SLOT_W-1:0] CH_F = 3'd5;
    localparam logic [SLOT_W-1:0] CH_G = 3'd6;
    localparam logic [SLOT_W-1:0] CH_H = 3'd7;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_slot_counter
//  Description : 3-bit slot counter. Clear-to-0 has priority over load-to-1,
//                which has priority over increment. Wraps 7 -> 0 naturally.
//                wrap_o flags the last slot of a frame (count = 7).
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] cnt_o,
    output logic              wrap_o
);

    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] cnt_d;

    // Next-count selection with fixed priority clear > load > increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CH_A;
        end else if (load1_i) begin
            cnt_d = CH_B;
        end else if (inc_i) begin
            cnt_d = cnt_q + SLOT_W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= CH_A;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == CH_H);

endmodule : tdm_slot_counter
`default_nettype wire

// File: rtl/tdm_demux8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux8_seq
//  Description : Sequential 1:8 TDM demultiplexer. Aligns to SYNC on slot 0,
//                collects slots 0..6 in a shadow buffer and, on the slot-7
//                sample, transfers the complete frame to Y with a one-cycle
//                FRAME_VALID pulse. Sync violations pulse SYNC_ERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux8_seq
    import tdm_pkg::*;
#(
    parameter int DATA_W = 1
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       DIN,
    input  logic                    EN,
    input  logic                    SYNC,
    output logic [SLOTS*DATA_W-1:0] Y,
    output logic [SLOT_W-1:0]       SLOT,
    output logic                    LOCKED,
    output logic                    FRAME_VALID,
    output logic                    SYNC_ERR
);

    state_e                    state_q;
    state_e                    state_d;
    logic [SLOT_W-1:0]         slot;
    logic                      slot_wrap;
    logic                      cnt_clr;
    logic                      cnt_load1;
    logic                      cnt_inc;
    logic                      sh_wr;
    logic [SLOT_W-1:0]         sh_idx;
    logic                      y_load;
    logic                      fv_d;
    logic                      fv_q;
    logic                      err_d;
    logic                      err_q;
    logic [SLOTS*DATA_W-1:0]   frame_w;
    logic [SLOTS*DATA_W-1:0]   y_q;

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .load1_i (cnt_load1),
        .inc_i   (cnt_inc),
        .cnt_o   (slot),
        .wrap_o  (slot_wrap)
    );

    // Alignment FSM: decides counter action, shadow write, frame transfer
    // and the status pulses for each qualified sample.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        sh_wr     = 1'b0;
        sh_idx    = CH_A;
        y_load    = 1'b0;
        fv_d      = 1'b0;
        err_d     = 1'b0;
        if (EN) begin
            case (state_q)
                HUNT: begin
                    if (SYNC) begin
                        sh_wr     = 1'b1;
                        cnt_load1 = 1'b1;
                        state_d   = LOCK;
                    end
                end
                LOCK: begin
                    if (SYNC) begin
                        // A sync anywhere but slot 0 abandons the partial
                        // frame and realigns on this sample.
                        err_d     = (slot != CH_A);
                        sh_wr     = 1'b1;
                        cnt_load1 = 1'b1;
                    end else if (slot == CH_A) begin
                        err_d   = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = HUNT;
                    end else if (slot_wrap) begin
                        y_load  = 1'b1;
                        fv_d    = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        sh_wr   = 1'b1;
                        sh_idx  = slot;
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State and status-pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    // Shadow buffer for slots 0..6; slot 7 goes straight from DIN to Y.
    for (genvar k = 0; k < SLOTS - 1; k++) begin : g_shadow
        logic [DATA_W-1:0] sh_q;

        // One shadow entry, written when its slot index is selected.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sh_q <= '0;
            end else if (sh_wr && (sh_idx == SLOT_W'(k))) begin
                sh_q <= DIN;
            end
        end

        assign frame_w[k*DATA_W +: DATA_W] = sh_q;
    end

    assign frame_w[SLOTS*DATA_W-1 -: DATA_W] = DIN;

    // Output frame register: updated only when a complete frame finishes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q <= '0;
        end else if (y_load) begin
            y_q <= frame_w;
        end
    end

    assign Y           = y_q;
    assign SLOT        = slot;
    assign LOCKED      = (state_q == LOCK);
    assign FRAME_VALID = fv_q;
    assign SYNC_ERR    = err_q;

endmodule : tdm_demux8_seq
`default_nettype wire

// File: tb/tb_tdm_demux8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux8_seq
//  Description : Self-checking bench for tdm_demux8_seq (4-bit channels).
//                A frame-level reference model (sample queue) predicts every
//                output after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8_seq;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sync;
    logic [DW-1:0] din;
    logic [8*DW-1:0] y;
    logic [2:0]    slot;
    logic          locked;
    logic          fv;
    logic          serr;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_count = 0;

    // Reference model: samples of the frame in progress, lock flag, last frame.
    bit            m_locked = 1'b0;
    logic [DW-1:0] m_q[$];
    logic [31:0]   m_y = '0;
    bit            m_fv = 1'b0;
    bit            m_err = 1'b0;

    always #5 clk = ~clk;

    tdm_demux8_seq #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DIN         (din),
        .EN          (en),
        .SYNC        (sync),
        .Y           (y),
        .SLOT        (slot),
        .LOCKED      (locked),
        .FRAME_VALID (fv),
        .SYNC_ERR    (serr)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_slot();
        return m_locked ? m_q.size() : 0;
    endfunction

    task automatic model_edge(bit r, bit e, bit s, logic [DW-1:0] d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!r) begin
            m_locked = 1'b0;
            m_q.delete();
            m_y = '0;
        end else if (e) begin
            if (s) begin
                if (m_locked && m_q.size() != 0) m_err = 1'b1;
                m_q.delete();
                m_q.push_back(d);
                m_locked = 1'b1;
            end else if (m_locked) begin
                if (m_q.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_q.push_back(d);
                    if (m_q.size() == 8) begin
                        m_y = '0;
                        for (int i = 0; i < 8; i++) m_y |= 32'(m_q[i]) << (DW * i);
                        m_fv = 1'b1;
                        m_q.delete();
                    end
                end
            end
        end
    endtask

    task automatic step(bit r, bit e, bit s, logic [DW-1:0] d);
        rst_n = r;
        en    = e;
        sync  = s;
        din   = d;
        @(posedge clk);
        model_edge(r, e, s, d);
        #1;
        if (fv === 1'b1) fv_count++;
        chk("Y", y, m_y);
        chk("SLOT", 32'(slot), 32'(m_slot()));
        chk("LOCKED", 32'(locked), 32'(m_locked));
        chk("FRAME_VALID", 32'(fv), 32'(m_fv));
        chk("SYNC_ERR", 32'(serr), 32'(m_err));
        chk("FV_ERR_EXCL", 32'(fv & serr), 32'd0);
    endtask

    initial begin
        int          fv0;
        logic [31:0] y_prev;
        bit          r;
        bit          e;
        bit          s;

        rst_n = 1'b0;
        en    = 1'b1;
        sync  = 1'b1;
        din   = '0;

        // Reset held for two edges with EN and SYNC active.
        step(1'b0, 1'b1, 1'b1, 4'hF);
        step(1'b0, 1'b1, 1'b1, 4'hF);
        chk("rst_Y", y, 32'd0);
        chk("rst_SLOT", 32'(slot), 32'd0);
        chk("rst_LOCKED", 32'(locked), 32'd0);
        chk("rst_FV", 32'(fv), 32'd0);
        chk("rst_ERR", 32'(serr), 32'd0);

        // One-hot walk across the eight slots.
        for (int j = 0; j < 8; j++) begin
            fv0 = fv_count;
            for (int k = 0; k < 8; k++) step(1'b1, 1'b1, k == 0, (k == j) ? 4'h1 : 4'h0);
            chk("walk_Y", y, 32'h1 << (DW * j));
            chk("walk_fv_pulses", 32'(fv_count - fv0), 32'd1);
        end

        // Frame 1..8 with a three-cycle EN gap between slots 3 and 4.
        fv0 = fv_count;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, k == 0, 4'(k + 1));
        for (int g = 0; g < 3; g++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom));
            chk("gap_SLOT", 32'(slot), 32'd4);
        end
        for (int k = 4; k < 8; k++) step(1'b1, 1'b1, 1'b0, 4'(k + 1));
        chk("gap_Y", y, 32'h8765_4321);
        chk("gap_fv_pulses", 32'(fv_count - fv0), 32'd1);

        // Early sync at slot 5, then the realigned frame completes.
        y_prev = y;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k == 0, 4'($urandom));
        step(1'b1, 1'b1, 1'b1, 4'hA);
        chk("early_ERR", 32'(serr), 32'd1);
        chk("early_LOCKED", 32'(locked), 32'd1);
        chk("early_SLOT", 32'(slot), 32'd1);
        chk("early_Y_hold", y, y_prev);
        for (int k = 1; k < 8; k++) step(1'b1, 1'b1, 1'b0, 4'(k));
        chk("early_next_Y", y, 32'h7654_321A);

        // Missing sync at slot 0, ignored samples, then a fresh frame.
        step(1'b1, 1'b1, 1'b0, 4'h5);
        chk("miss_ERR", 32'(serr), 32'd1);
        chk("miss_LOCKED", 32'(locked), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 4'($urandom));
        chk("miss_Y_hold", y, 32'h7654_321A);
        fv0 = fv_count;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, k == 0, 4'(k + 8));
        chk("miss_next_Y", y, 32'hFEDC_BA98);
        chk("miss_fv_pulses", 32'(fv_count - fv0), 32'd1);

        // Reset in the middle of a frame.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, k == 0, 4'($urandom));
        step(1'b0, 1'b1, 1'b0, 4'h3);
        chk("midrst_Y", y, 32'd0);
        chk("midrst_SLOT", 32'(slot), 32'd0);
        chk("midrst_LOCKED", 32'(locked), 32'd0);
        fv0 = fv_count;
        for (int k = 5; k < 8; k++) step(1'b1, 1'b1, 1'b0, 4'($urandom));
        chk("midrst_no_fv", 32'(fv_count - fv0), 32'd0);

        // Randomized traffic: mostly well-formed frames with occasional
        // EN gaps, stray or missing syncs and rare resets.
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 3) != 0);
            if (m_slot() == 0) s = ($urandom_range(0, 9) != 0);
            else               s = ($urandom_range(0, 19) == 0);
            step(r, e, s, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tdm_demux8_seq
`default_nettype wire
